// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: general-purpose register file (R0..R14) with two
// write-back ports, NUM_RD combinational read ports with write-through bypass,
// and a per-register pending-write counter used for RAW hazard detection.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   wr0_en/addr/data             write port 0 (ALU write-back, wins on collision)
//   wr1_en/addr/data             write port 1 (load write-back)
//   rd_addr / rd_data            packed read ports, port k at [k*W +: W]
//   rd_busy                      per read port: source has an outstanding producer
//   iss_en / iss_dst / iss_stall issue of a producer; stall when counter saturated
//   flush                        clear all pending counters
//   busy_vec                     registered view: bit r = (pend[r] != 0)
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 15,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_RD   = 3,
  parameter int unsigned PEND_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_dst,
  output logic                       iss_stall,
  input  logic                       flush,
  output logic [NUM_REGS-1:0]        busy_vec
);

  localparam int unsigned CNT_W = PEND_W + 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [PEND_W-1:0] r_pend [NUM_REGS];

  logic [1:0]        w_dec      [NUM_REGS];
  logic [PEND_W-1:0] w_pend_nxt [NUM_REGS];
  logic              w_iss_valid;
  logic              w_iss_wr;
  logic [PEND_W-1:0] w_iss_pend;

  // Number of writes retiring into each register this cycle (0..2).
  always_comb begin
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      w_dec[r] = 2'(wr0_en && (wr0_addr == ADDR_W'(r)))
               + 2'(wr1_en && (wr1_addr == ADDR_W'(r)));
    end
  end

  // Issue stall: counter saturated and no write frees a slot this cycle.
  always_comb begin
    w_iss_valid = iss_en && (32'(iss_dst) < NUM_REGS);
    w_iss_wr    = (wr0_en && (wr0_addr == iss_dst)) ||
                  (wr1_en && (wr1_addr == iss_dst));
    w_iss_pend  = '0;
    if (w_iss_valid) w_iss_pend = r_pend[iss_dst];
    iss_stall   = w_iss_valid && !flush && (w_iss_pend == PEND_MAX) && !w_iss_wr;
  end

  // Next pending count: +issue -writes, clamped at zero; flush clears all.
  always_comb begin
    logic [CNT_W-1:0] v_sum;
    logic [CNT_W-1:0] v_dec;
    v_sum = '0;
    v_dec = '0;
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      v_sum = {1'b0, r_pend[r]}
            + CNT_W'(w_iss_valid && !iss_stall && (iss_dst == ADDR_W'(r)));
      v_dec = CNT_W'(w_dec[r]);
      if (flush || (v_sum < v_dec)) begin
        w_pend_nxt[r] = '0;
      end else begin
        w_pend_nxt[r] = PEND_W'(v_sum - v_dec);
      end
    end
  end

  // Read ports with bypass; busy already discounts writes landing this cycle.
  always_comb begin
    logic [ADDR_W-1:0] v_addr;
    logic              v_valid;
    rd_data = '0;
    rd_busy = '0;
    v_addr  = '0;
    v_valid = 1'b0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      v_addr  = rd_addr[k*ADDR_W +: ADDR_W];
      v_valid = 32'(v_addr) < NUM_REGS;
      if (v_valid) begin
        if (wr0_en && (wr0_addr == v_addr)) begin
          rd_data[k*DATA_W +: DATA_W] = wr0_data;
        end else if (wr1_en && (wr1_addr == v_addr)) begin
          rd_data[k*DATA_W +: DATA_W] = wr1_data;
        end else begin
          rd_data[k*DATA_W +: DATA_W] = r_regs[v_addr];
        end
        rd_busy[k] = {1'b0, r_pend[v_addr]} > CNT_W'(w_dec[v_addr]);
      end
    end
  end

  // State: register array, pending counters and their registered busy view.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        r_regs[r] <= '0;
        r_pend[r] <= '0;
      end
      busy_vec <= '0;
    end else begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        if (wr0_en && (wr0_addr == ADDR_W'(r))) begin
          r_regs[r] <= wr0_data;
        end else if (wr1_en && (wr1_addr == ADDR_W'(r))) begin
          r_regs[r] <= wr1_data;
        end
        r_pend[r]   <= w_pend_nxt[r];
        busy_vec[r] <= |w_pend_nxt[r];
      end
    end
  end

endmodule
